// File: rtl/reorder_buffer_if.sv
// Decoder / CDB / register-file / commit bundle of the reorder buffer.
// The core side drives through master; the buffer uses slave.
interface reorder_buffer_if #(
    parameter int unsigned ROB_WIDTH = 3,
    parameter int unsigned REG_WIDTH = 5
);
    logic                 dec_valid;
    logic [REG_WIDTH-1:0] dec_reg_id;
    logic                 dec_ready;
    logic [31:0]          dec_data;
    logic [ROB_WIDTH-1:0] dec_rob_id;
    logic                 rob_full;

    logic                 cdb_valid;
    logic [ROB_WIDTH-1:0] cdb_rob_id;
    logic [31:0]          cdb_data;
    logic                 cdb_mispredict;
    logic [31:0]          cdb_redirect_pc;

    logic [ROB_WIDTH-1:0] rf_rob_id_j;
    logic [ROB_WIDTH-1:0] rf_rob_id_k;
    logic                 rf_ready_j;
    logic [31:0]          rf_data_j;
    logic                 rf_ready_k;
    logic [31:0]          rf_data_k;

    logic [REG_WIDTH-1:0] commit_reg_id;
    logic [31:0]          commit_data;
    logic [ROB_WIDTH-1:0] commit_rob_id;
    logic                 flush;
    logic [31:0]          flush_pc;

    modport master (
        output dec_valid, dec_reg_id, dec_ready, dec_data,
        output cdb_valid, cdb_rob_id, cdb_data, cdb_mispredict, cdb_redirect_pc,
        output rf_rob_id_j, rf_rob_id_k,
        input  dec_rob_id, rob_full, rf_ready_j, rf_data_j, rf_ready_k, rf_data_k,
        input  commit_reg_id, commit_data, commit_rob_id, flush, flush_pc
    );

    modport slave (
        input  dec_valid, dec_reg_id, dec_ready, dec_data,
        input  cdb_valid, cdb_rob_id, cdb_data, cdb_mispredict, cdb_redirect_pc,
        input  rf_rob_id_j, rf_rob_id_k,
        output dec_rob_id, rob_full, rf_ready_j, rf_data_j, rf_ready_k, rf_data_k,
        output commit_reg_id, commit_data, commit_rob_id, flush, flush_pc
    );
endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order retirement buffer: allocates ids, captures CDB results, retires the head.
// Optional ROB_CDB_BYPASS_EN forwards a same-cycle CDB result to register-file queries.
module reorder_buffer #(
    parameter int unsigned ROB_WIDTH = 3,
    parameter int unsigned REG_WIDTH = 5
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic rdy_in,
    reorder_buffer_if.slave rob
);
    localparam int unsigned ROB_SIZE = 1 << ROB_WIDTH;
    localparam int unsigned COUNT_W  = ROB_WIDTH + 1;

    logic [ROB_SIZE-1:0]  busy;
    logic [ROB_SIZE-1:0]  ready;
    logic [ROB_SIZE-1:0]  mispredict;
    logic [REG_WIDTH-1:0] dest      [ROB_SIZE];
    logic [31:0]          value     [ROB_SIZE];
    logic [31:0]          target_pc [ROB_SIZE];
    logic [ROB_WIDTH-1:0] head;
    logic [ROB_WIDTH-1:0] tail;
    logic [COUNT_W-1:0]   count;

    logic full;
    logic can_commit;
    logic do_flush;
    logic do_issue;
    logic do_cdb;

    // Event qualification; full is taken before this cycle's retirement.
    always_comb begin
        full       = (count == COUNT_W'(ROB_SIZE));
        can_commit = rdy_in && (count != '0) && ready[head];
        do_flush   = can_commit && mispredict[head];
        do_issue   = rdy_in && rob.dec_valid && !full && !do_flush;
        do_cdb     = rdy_in && rob.cdb_valid && !do_flush && busy[rob.cdb_rob_id];
    end

    // Combinational outputs: allocation, commit port and operand queries.
    always_comb begin
        rob.dec_rob_id    = tail;
        rob.rob_full      = full;
        rob.commit_reg_id = '0;
        rob.commit_data   = '0;
        rob.commit_rob_id = '0;
        rob.flush         = 1'b0;
        rob.flush_pc      = '0;
        if (can_commit) begin
            rob.commit_reg_id = dest[head];
            rob.commit_data   = value[head];
            rob.commit_rob_id = head;
            rob.flush         = mispredict[head];
            rob.flush_pc      = mispredict[head] ? target_pc[head] : 32'd0;
        end
        rob.rf_ready_j = busy[rob.rf_rob_id_j] && ready[rob.rf_rob_id_j];
        rob.rf_data_j  = value[rob.rf_rob_id_j];
        rob.rf_ready_k = busy[rob.rf_rob_id_k] && ready[rob.rf_rob_id_k];
        rob.rf_data_k  = value[rob.rf_rob_id_k];
`ifdef ROB_CDB_BYPASS_EN
        if (rob.cdb_valid && (rob.cdb_rob_id == rob.rf_rob_id_j)) begin
            rob.rf_ready_j = 1'b1;
            rob.rf_data_j  = rob.cdb_data;
        end
        if (rob.cdb_valid && (rob.cdb_rob_id == rob.rf_rob_id_k)) begin
            rob.rf_ready_k = 1'b1;
            rob.rf_data_k  = rob.cdb_data;
        end
`endif
    end

    // Entry state, pointers and occupancy.
    always_ff @(posedge clk_in) begin
        if (rst_in || (rdy_in && do_flush)) begin
            busy       <= '0;
            ready      <= '0;
            mispredict <= '0;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
        end else if (rdy_in) begin
            if (do_cdb) begin
                ready[rob.cdb_rob_id]      <= 1'b1;
                value[rob.cdb_rob_id]      <= rob.cdb_data;
                mispredict[rob.cdb_rob_id] <= rob.cdb_mispredict;
                target_pc[rob.cdb_rob_id]  <= rob.cdb_redirect_pc;
            end
            if (do_issue) begin
                busy[tail]       <= 1'b1;
                ready[tail]      <= rob.dec_ready;
                value[tail]      <= rob.dec_data;
                dest[tail]       <= rob.dec_reg_id;
                mispredict[tail] <= 1'b0;
                tail             <= tail + ROB_WIDTH'(1);
            end
            // Retirement is last so it wins over a stale CDB write to the head.
            if (can_commit) begin
                busy[head]  <= 1'b0;
                ready[head] <= 1'b0;
                head        <= head + ROB_WIDTH'(1);
            end
            count <= count + COUNT_W'(do_issue) - COUNT_W'(can_commit);
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer: issue, CDB capture, commit,
// full/wrap, query forwarding, mispredict flush and rdy_in stall.
module tb_reorder_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b1;
    int   checks = 0;
    int   errors = 0;

    reorder_buffer_if #(.ROB_WIDTH(3), .REG_WIDTH(5)) rob ();

    reorder_buffer #(.ROB_WIDTH(3), .REG_WIDTH(5)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .rdy_in (rdy),
        .rob    (rob)
    );

    initial forever #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cdb(input int id, input logic [31:0] data);
        rob.cdb_valid       = 1'b1;
        rob.cdb_rob_id      = 3'(id);
        rob.cdb_data        = data;
        rob.cdb_mispredict  = 1'b0;
        rob.cdb_redirect_pc = '0;
    endtask

    task automatic issue(input int reg_id);
        rob.dec_valid  = 1'b1;
        rob.dec_reg_id = 5'(reg_id);
        rob.dec_ready  = 1'b0;
        rob.dec_data   = '0;
    endtask

    initial begin
        rob.dec_valid = 0; rob.dec_reg_id = '0; rob.dec_ready = 0; rob.dec_data = '0;
        rob.cdb_valid = 0; rob.cdb_rob_id = '0; rob.cdb_data = '0;
        rob.cdb_mispredict = 0; rob.cdb_redirect_pc = '0;
        rob.rf_rob_id_j = '0; rob.rf_rob_id_k = '0;

        // Reset state
        tick();
        rst = 1'b0;
        #1;
        chk("rst_dec_rob_id", 32'(rob.dec_rob_id), 0);
        chk("rst_full", 32'(rob.rob_full), 0);
        chk("rst_commit_reg", 32'(rob.commit_reg_id), 0);
        chk("rst_commit_data", rob.commit_data, 0);
        chk("rst_commit_rob", 32'(rob.commit_rob_id), 0);
        chk("rst_flush", 32'(rob.flush), 0);
        chk("rst_flush_pc", rob.flush_pc, 0);

        // Issue x1, x2, x3
        for (int i = 0; i < 3; i++) begin
            issue(i + 1);
            #1;
            chk("alloc_id", 32'(rob.dec_rob_id), 32'(i));
            chk("alloc_no_commit", 32'(rob.commit_reg_id), 0);
            tick();
        end
        rob.dec_valid = 1'b0;
        #1;
        chk("alloc_tail3", 32'(rob.dec_rob_id), 3);

        // Out-of-order completion, in-order retirement
        cdb(2, 32'h33);
        tick();
        cdb(0, 32'h11);
        #1;
        chk("no_cdb_commit_bypass", 32'(rob.commit_reg_id), 0);
        tick();
        cdb(1, 32'h22);
        #1;
        chk("c0_reg", 32'(rob.commit_reg_id), 1);
        chk("c0_data", rob.commit_data, 32'h11);
        chk("c0_rob", 32'(rob.commit_rob_id), 0);
        tick();
        rob.cdb_valid = 1'b0;
        #1;
        chk("c1_reg", 32'(rob.commit_reg_id), 2);
        chk("c1_data", rob.commit_data, 32'h22);
        tick();
        chk("c2_reg", 32'(rob.commit_reg_id), 3);
        chk("c2_data", rob.commit_data, 32'h33);
        chk("c2_rob", 32'(rob.commit_rob_id), 2);
        tick();
        chk("empty_commit", 32'(rob.commit_reg_id), 0);

        // Fill all 8 entries starting from id 3
        for (int k = 0; k < 8; k++) begin
            issue(10 + k);
            #1;
            chk("fill_not_full", 32'(rob.rob_full), 0);
            chk("fill_id", 32'(rob.dec_rob_id), 32'((3 + k) % 8));
            tick();
        end
        issue(9);
        cdb(3, 32'hA0);
        #1;
        chk("full", 32'(rob.rob_full), 1);
        chk("full_tail", 32'(rob.dec_rob_id), 3);
        chk("full_no_commit", 32'(rob.commit_reg_id), 0);
        tick();
        rob.cdb_valid = 1'b0;
        #1;
        chk("full_commit_full", 32'(rob.rob_full), 1);
        chk("full_commit_reg", 32'(rob.commit_reg_id), 10);
        chk("full_commit_data", rob.commit_data, 32'hA0);
        tick();
        rob.dec_valid = 1'b0;
        #1;
        chk("ninth_rejected_full", 32'(rob.rob_full), 0);
        chk("ninth_rejected_tail", 32'(rob.dec_rob_id), 3);
        for (int k = 1; k < 8; k++) begin
            cdb((3 + k) % 8, 32'hA0 + 32'(k));
            tick();
            rob.cdb_valid = 1'b0;
            #1;
            chk("drain_rob", 32'(rob.commit_rob_id), 32'((3 + k) % 8));
            chk("drain_reg", 32'(rob.commit_reg_id), 32'(10 + k));
            chk("drain_data", rob.commit_data, 32'hA0 + 32'(k));
        end
        tick();
        chk("drained_commit", 32'(rob.commit_reg_id), 0);
        chk("drained_full", 32'(rob.rob_full), 0);
        chk("wrapped_tail", 32'(rob.dec_rob_id), 3);

        // Register-file query with and without CDB forwarding
        issue(5);
        tick();
        issue(6);
        tick();
        rob.dec_valid   = 1'b0;
        rob.rf_rob_id_j = 3'd4;
        rob.rf_rob_id_k = 3'd3;
        cdb(4, 32'h55);
        #1;
`ifdef ROB_CDB_BYPASS_EN
        chk("q_same_ready", 32'(rob.rf_ready_j), 1);
        chk("q_same_data", rob.rf_data_j, 32'h55);
`else
        chk("q_same_ready", 32'(rob.rf_ready_j), 0);
`endif
        chk("q_k_not_ready", 32'(rob.rf_ready_k), 0);
        tick();
        rob.cdb_valid = 1'b0;
        #1;
        chk("q_next_ready", 32'(rob.rf_ready_j), 1);
        chk("q_next_data", rob.rf_data_j, 32'h55);
        chk("q_head_blocked", 32'(rob.commit_reg_id), 0);
        cdb(3, 32'h44);
        tick();
        rob.cdb_valid = 1'b0;
        #1;
        chk("q_c3_reg", 32'(rob.commit_reg_id), 5);
        chk("q_c3_data", rob.commit_data, 32'h44);
        chk("q_k_ready", 32'(rob.rf_ready_k), 1);
        chk("q_k_data", rob.rf_data_k, 32'h44);
        tick();
        chk("q_c4_reg", 32'(rob.commit_reg_id), 6);
        chk("q_c4_rob", 32'(rob.commit_rob_id), 4);
        tick();
        chk("q_retired_j", 32'(rob.rf_ready_j), 0);

        // Mispredicted branch at rob1 flushes the buffer
        rst = 1'b1;
        tick();
        rst = 1'b0;
        issue(7); tick();
        issue(1); tick();
        issue(2); tick();
        issue(3); tick();
        rob.dec_valid = 1'b0;
        cdb(1, 32'h104);
        rob.cdb_mispredict  = 1'b1;
        rob.cdb_redirect_pc = 32'h100;
        tick();
        cdb(0, 32'h70);
        #1;
        chk("br_no_flush_yet", 32'(rob.flush), 0);
        tick();
        rob.cdb_valid = 1'b0;
        #1;
        chk("br_c0_reg", 32'(rob.commit_reg_id), 7);
        chk("br_c0_flush", 32'(rob.flush), 0);
        chk("br_c0_flush_pc", rob.flush_pc, 0);
        tick();
        issue(9);
        cdb(2, 32'h22);
        #1;
        chk("br_flush", 32'(rob.flush), 1);
        chk("br_flush_pc", rob.flush_pc, 32'h100);
        chk("br_link_reg", 32'(rob.commit_reg_id), 1);
        chk("br_link_data", rob.commit_data, 32'h104);
        chk("br_link_rob", 32'(rob.commit_rob_id), 1);
        chk("br_tail_before", 32'(rob.dec_rob_id), 4);
        tick();
        rob.dec_valid   = 1'b0;
        rob.cdb_valid   = 1'b0;
        rob.rf_rob_id_j = 3'd2;
        #1;
        chk("post_flush", 32'(rob.flush), 0);
        chk("post_flush_pc", rob.flush_pc, 0);
        chk("post_flush_tail", 32'(rob.dec_rob_id), 0);
        chk("post_flush_full", 32'(rob.rob_full), 0);
        chk("post_flush_commit", 32'(rob.commit_reg_id), 0);
        chk("post_flush_cdb_dropped", 32'(rob.rf_ready_j), 0);

        // rdy_in low stalls everything
        issue(4);
        rob.dec_ready = 1'b1;
        rob.dec_data  = 32'hAB;
        tick();
        rdy = 1'b0;
        issue(8);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("stall_commit_reg", 32'(rob.commit_reg_id), 0);
            chk("stall_commit_data", rob.commit_data, 0);
            chk("stall_flush", 32'(rob.flush), 0);
            chk("stall_tail", 32'(rob.dec_rob_id), 1);
            tick();
        end
        rdy = 1'b1;
        rob.dec_valid = 1'b0;
        #1;
        chk("resume_reg", 32'(rob.commit_reg_id), 4);
        chk("resume_data", rob.commit_data, 32'hAB);
        chk("resume_rob", 32'(rob.commit_rob_id), 0);
        chk("resume_tail", 32'(rob.dec_rob_id), 1);
        tick();
        chk("resume_empty", 32'(rob.commit_reg_id), 0);
        chk("resume_tail_held", 32'(rob.dec_rob_id), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
